// File: rtl/jtframe_ioctl_pkg.sv
// rtl/jtframe_ioctl_pkg.sv - shared index codes, FSM states and helpers for the ioctl decoder
package jtframe_ioctl_pkg;

    localparam logic [7:0] IDX_ROM_DEF   = 8'd0;
    localparam logic [7:0] IDX_MOD_DEF   = 8'd1;
    localparam logic [7:0] IDX_NVRAM_DEF = 8'd2;
    localparam logic [7:0] IDX_DIPSW_DEF = 8'd254;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Byte lanes carried by one ioctl write.
    function automatic int lanes_of(input int wide);
        return (wide != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/jtframe_ioctl_cfg_if.sv
// rtl/jtframe_ioctl_cfg_if.sv - hps_io ioctl download bus
interface jtframe_ioctl_cfg_if #(
    parameter int DW = 8
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [DW-1:0] ioctl_dout;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
    );

    modport slave (
        input ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
    );
endinterface

// File: rtl/jtframe_ioctl_shadow.sv
// rtl/jtframe_ioctl_shadow.sv - byte-addressed shadow register with masked commit to a live copy
module jtframe_ioctl_shadow #(
    parameter int             NB      = 4,
    parameter int             LANES   = 1,
    parameter logic [NB*8-1:0] RST_VAL = '0
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr,
    input  logic [24:0]        addr,
    input  logic [LANES*8-1:0] din,
    input  logic               commit,
    output logic [NB*8-1:0]    q,
    output logic               any
);

    logic [NB*8-1:0] sh_q, sh_d;
    logic [NB*8-1:0] live_q, live_d;
    logic [NB-1:0]   en_q, en_d;

    always_comb begin
        sh_d   = sh_q;
        en_d   = en_q;
        live_d = live_q;
        if (clr) begin
            en_d = '0;
        end
        // Lanes landing past the last byte simply match no slot and are dropped.
        if (wr) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < NB; b++) begin
                    if (({1'b0, addr} + 26'(l)) == 26'(b)) begin
                        sh_d[b*8 +: 8] = din[l*8 +: 8];
                        en_d[b]        = 1'b1;
                    end
                end
            end
        end
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (en_q[b]) begin
                    live_d[b*8 +: 8] = sh_q[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            en_q   <= '0;
            live_q <= RST_VAL;
        end else begin
            sh_q   <= sh_d;
            en_q   <= en_d;
            live_q <= live_d;
        end
    end

    assign q   = live_q;
    assign any = |en_q;

endmodule

// File: rtl/jtframe_ioctl_cfg.sv
// rtl/jtframe_ioctl_cfg.sv - classifies ioctl downloads, forwards ROM/NVRAM writes, commits DIP/mod shadows
module jtframe_ioctl_cfg
    import jtframe_ioctl_pkg::*;
#(
    parameter int              DIPW        = 32,
    parameter int              MODW        = 7,
    parameter int              WIDE        = 0,
    parameter logic [7:0]      IDX_ROM     = IDX_ROM_DEF,
    parameter logic [7:0]      IDX_MOD     = IDX_MOD_DEF,
    parameter logic [7:0]      IDX_NVRAM   = IDX_NVRAM_DEF,
    parameter logic [7:0]      IDX_DIPSW   = IDX_DIPSW_DEF,
    parameter logic [DIPW-1:0] DIP_DEFAULT = '1,
    parameter logic [MODW-1:0] MOD_DEFAULT = MODW'(1),
    localparam int             LANES       = lanes_of(WIDE),
    localparam int             DW          = LANES * 8
)(
    input  logic                clk_rom,
    input  logic                rst_n,
    jtframe_ioctl_cfg_if.slave  ioctl,
    output logic                downloading,
    output logic                ioctl_ram,
    output logic                rom_wr,
    output logic [24:0]         rom_addr,
    output logic [DW-1:0]       rom_data,
    output logic [DIPW-1:0]     dipsw,
    output logic [MODW-1:0]     core_mod,
    output logic                cfg_valid,
    output logic                dwn_start,
    output logic                dwn_done,
    output logic [24:0]         dwn_bytes
);

    state_t        state_q, state_d;
    logic [7:0]    act_idx_q, act_idx_d;
    logic [24:0]   dwn_bytes_q, dwn_bytes_d;
    logic          dwn_start_q, dwn_start_d;
    logic          dwn_done_q, dwn_done_d;
    logic          cfg_valid_q, cfg_valid_d;
    logic          rom_wr_q, rom_wr_d;
    logic [24:0]   rom_addr_q, rom_addr_d;
    logic [DW-1:0] rom_data_q, rom_data_d;

    logic        sh_clr, sh_commit, dip_wr, mod_wr;
    logic        wr_ok;
    logic [24:0] wr_end;
    logic        dip_any, mod_any;
    logic [7:0]  mod_live;
    logic        unused_mod;

    always_comb begin
        state_d     = state_q;
        act_idx_d   = act_idx_q;
        dwn_bytes_d = dwn_bytes_q;
        dwn_start_d = 1'b0;
        dwn_done_d  = 1'b0;
        cfg_valid_d = cfg_valid_q;
        rom_wr_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        sh_clr      = 1'b0;
        sh_commit   = 1'b0;
        dip_wr      = 1'b0;
        mod_wr      = 1'b0;
        wr_ok       = ioctl.ioctl_wr && (ioctl.ioctl_index == act_idx_q);
        wr_end      = ioctl.ioctl_addr + 25'(LANES);

        case (state_q)
            IDLE: begin
                if (ioctl.ioctl_download) begin
                    act_idx_d   = ioctl.ioctl_index;
                    sh_clr      = 1'b1;
                    dwn_bytes_d = '0;
                    dwn_start_d = 1'b1;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                // A write on the cycle download drops is still taken here.
                if (wr_ok) begin
                    dip_wr = (act_idx_q == IDX_DIPSW);
                    mod_wr = (act_idx_q == IDX_MOD);
                    if (act_idx_q == IDX_ROM || act_idx_q == IDX_NVRAM) begin
                        rom_wr_d   = 1'b1;
                        rom_addr_d = ioctl.ioctl_addr;
                        rom_data_d = ioctl.ioctl_dout;
                    end
                    if (wr_end > dwn_bytes_q) begin
                        dwn_bytes_d = wr_end;
                    end
                end
                if (!ioctl.ioctl_download) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                sh_commit  = 1'b1;
                dwn_done_d = 1'b1;
                if (dip_any) begin
                    cfg_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_idx_q   <= '0;
            dwn_bytes_q <= '0;
            dwn_start_q <= 1'b0;
            dwn_done_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            rom_wr_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            act_idx_q   <= act_idx_d;
            dwn_bytes_q <= dwn_bytes_d;
            dwn_start_q <= dwn_start_d;
            dwn_done_q  <= dwn_done_d;
            cfg_valid_q <= cfg_valid_d;
            rom_wr_q    <= rom_wr_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
        end
    end

    jtframe_ioctl_shadow #(
        .NB      (DIPW / 8),
        .LANES   (LANES),
        .RST_VAL (DIP_DEFAULT)
    ) u_dip (
        .clk    (clk_rom),
        .rst_n  (rst_n),
        .clr    (sh_clr),
        .wr     (dip_wr),
        .addr   (ioctl.ioctl_addr),
        .din    (ioctl.ioctl_dout),
        .commit (sh_commit),
        .q      (dipsw),
        .any    (dip_any)
    );

    // One-byte shadow: the high lane of a wide write at addr 0 falls on byte 1 and is dropped.
    jtframe_ioctl_shadow #(
        .NB      (1),
        .LANES   (LANES),
        .RST_VAL (8'(MOD_DEFAULT))
    ) u_mod (
        .clk    (clk_rom),
        .rst_n  (rst_n),
        .clr    (sh_clr),
        .wr     (mod_wr),
        .addr   (ioctl.ioctl_addr),
        .din    (ioctl.ioctl_dout),
        .commit (sh_commit),
        .q      (mod_live),
        .any    (mod_any)
    );

    assign unused_mod  = ^{mod_any, mod_live};
    assign core_mod    = mod_live[MODW-1:0];
    assign downloading = (state_q == ACTIVE) && (act_idx_q == IDX_ROM);
    assign ioctl_ram   = (state_q == ACTIVE) && (act_idx_q == IDX_NVRAM);
    assign rom_wr      = rom_wr_q;
    assign rom_addr    = rom_addr_q;
    assign rom_data    = rom_data_q;
    assign cfg_valid   = cfg_valid_q;
    assign dwn_start   = dwn_start_q;
    assign dwn_done    = dwn_done_q;
    assign dwn_bytes   = dwn_bytes_q;

endmodule

// File: doc/jtframe_ioctl_cfg.md
# jtframe_ioctl_cfg

Parametrised MiSTer ioctl stream decoder sitting between `hps_io` and `jtframe_board`, on the `clk_rom` domain. Classifies each download by index (ROM, core-mod, NVRAM, DIP switches), forwards ROM/NVRAM writes, and captures DIP and core-mod bytes into shadow registers. Shadow contents are committed atomically when the download ends. Generalises DIP capture to any byte count, supports both 8-bit and 16-bit (fast I/O) ioctl buses, and reports download start, done and size.

## Interface
Parameters:
- `DIPW`, 32, DIP switch width in bits; multiple of 8, range 8..64
- `MODW`, 7, core_mod width in bits; range 1..8
- `WIDE`, 0, 1 selects a 16-bit ioctl bus (fast I/O); `DW = WIDE ? 16 : 8`
- `IDX_ROM`, 8'd0; `IDX_MOD`, 8'd1; `IDX_NVRAM`, 8'd2; `IDX_DIPSW`, 8'd254: index codes
- `DIP_DEFAULT`, all ones, `dipsw` value after reset
- `MOD_DEFAULT`, 1, `core_mod` value after reset

Ports:
- `clk_rom`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ioctl_download`  in  1  download in progress
- `ioctl_wr`  in  1  write strobe, one cycle
- `ioctl_index`  in  8  file index
- `ioctl_addr`  in  25  byte address; even when `WIDE=1`
- `ioctl_dout`  in  DW  data; when `WIDE=1`, low byte is at `addr` and high byte at `addr+1`
- `downloading`  out  1  ROM download active
- `ioctl_ram`  out  1  NVRAM download active
- `rom_wr`  out  1  forwarded write, ROM or NVRAM index
- `rom_addr`  out  25  forwarded address
- `rom_data`  out  DW  forwarded data
- `dipsw`  out  DIPW  committed DIP switches
- `core_mod`  out  MODW  committed core_mod
- `cfg_valid`  out  1  at least one DIP commit since reset
- `dwn_start`  out  1  one-cycle pulse when a download starts
- `dwn_done`  out  1  one-cycle pulse when a download ends
- `dwn_bytes`  out  25  highest written byte address + 1 for the last or current download

## Operation
State machine with states IDLE, ACTIVE and COMMIT.

- **IDLE**
  - When `ioctl_download`=1: latch `ioctl_index` into `act_idx`, clear the shadow byte-enable masks, clear `dwn_bytes`, pulse `dwn_start`, go to ACTIVE.
  - The first-cycle write is processed in ACTIVE only; hps_io never writes on its first download cycle.
- **ACTIVE**
  - Writes are accepted only when `ioctl_index == act_idx`. Writes with any other index are ignored.
  - `act_idx == IDX_DIPSW`:
    - Each byte whose address is below `DIPW/8` is written to shadow byte `addr` and its enable bit is set.
    - Bytes at higher addresses are dropped.
  - `act_idx == IDX_MOD`:
    - Only byte address 0 is captured; its bits `[MODW-1:0]` go to the mod shadow.
    - With `WIDE=0`, writes with `addr[0]=1` are ignored, as are all addresses above 0.
  - `act_idx` is ROM or NVRAM: the write is forwarded.
  - For every accepted write, `dwn_bytes` becomes max(`dwn_bytes`, `addr + (WIDE ? 2 : 1)`).
  - When `ioctl_download`=0, go to COMMIT.
- **COMMIT** (one cycle)
  - Bytes of `dipsw` whose enable bit is set load from the shadow; the other bytes keep their value.
  - If any DIP byte was written, set `cfg_valid`.
  - If the mod byte was written, `core_mod` loads from the mod shadow.
  - Pulse `dwn_done`, then go to IDLE.
- `downloading` = (state ACTIVE && `act_idx == IDX_ROM`). `ioctl_ram` = same condition with `IDX_NVRAM`.
- Boundary conditions:
  - A download with zero writes still pulses both `dwn_start` and `dwn_done`, commits nothing, and leaves `dwn_bytes` at 0.
  - A download that restarts during COMMIT is seen in IDLE one cycle later, so there is no lost start.
  - Reset in any state returns to IDLE, discards the shadows, and restores the defaults.

## Timing
- Reset values:
  - `dipsw`=DIP_DEFAULT, `core_mod`=MOD_DEFAULT.
  - All flags and pulses 0, `rom_addr`/`rom_data`/`dwn_bytes` 0, state IDLE.
- `rom_wr`/`rom_addr`/`rom_data`: registered, 1 cycle after `ioctl_wr`.
- `dwn_start`: 1 cycle after `ioctl_download` rises. `downloading`/`ioctl_ram`: asserted in that same cycle.
- `downloading`/`ioctl_ram`: fall 1 cycle after `ioctl_download` falls.
- `dwn_done` and the new `dipsw`/`core_mod` values: visible 2 cycles after `ioctl_download` falls.
- `dipsw` and `core_mod` never change outside COMMIT or reset, so they are glitch-free to the game.
- A write coincident with the falling edge of `ioctl_download` is still accepted.

## Structure
- Package `jtframe_ioctl_pkg`: index localparams and the state enum `{IDLE, ACTIVE, COMMIT}`.
- Sub-module `jtframe_ioctl_shadow`, parametrised by byte count:
  - byte-addressed shadow register with per-byte enable mask;
  - 1 or 2 byte lanes per write;
  - masked commit into the live register.
- Instantiate it twice: once for DIP (`DIPW/8` bytes), once for mod (1 byte).

## Test plan
- Reset, then idle -> `dipsw`=DIP_DEFAULT, `core_mod`=1, `cfg_valid`=0, all pulses 0.
- `WIDE=0`, `IDX_DIPSW` download writing bytes 0..3 = 12,34,56,78, plus byte 4 = FF -> after `dwn_done`, `dipsw`=32'h78563412, `cfg_valid`=1, `dwn_bytes`=5.
- `WIDE=1`, `IDX_DIPSW` download with a single write at addr 2, data 16'hBEEF -> `dipsw`=32'hBEEFFFFF (bytes 0,1 keep the default).
- `IDX_MOD` download with byte 0 = 8'h05, then addr 1 = 8'h00 -> `core_mod`=7'h05, unchanged before COMMIT.
- ROM download, 3 writes at addr 0..2 -> three `rom_wr` pulses 1 cycle later with matching addr/data; `downloading` high throughout; `dwn_bytes`=3.
- Assert `rst_n`=0 mid-DIP-download after 2 bytes -> `dipsw` returns to DIP_DEFAULT, no `dwn_done`, state IDLE.
